// File: rtl/chi_iter_engine.sv
// Iterated chi (revaluate) engine: holds a 5x5xW state and applies chi 0..MAX_ITER
// times per transaction, with registered valid/ready input and output stages.
module chi_iter_engine #(
    parameter int unsigned W        = 1,
    parameter int unsigned MAX_ITER = 24,
    parameter int unsigned CW       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [25*W-1:0]   in_data,
    input  logic [CW-1:0]     in_iter,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [25*W-1:0]   out_data,
    output logic              busy
);

    localparam int unsigned SW = 25 * W;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [SW-1:0]    state_q, state_d;
    logic [SW-1:0]    out_q, out_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [CW-1:0]    iter_clamped;
    logic [SW-1:0]    chi_next;

    // One chi round over the whole state; lane i = 5*y + x at bits [i*W +: W].
    function automatic logic [SW-1:0] chi(input logic [SW-1:0] a);
        logic [SW-1:0] r;
        int unsigned   l0, l1, l2;
        r = '0;
        for (int unsigned y = 0; y < 5; y++) begin
            for (int unsigned x = 0; x < 5; x++) begin
                l0 = (5 * y + x) * W;
                l1 = (5 * y + (x + 1) % 5) * W;
                l2 = (5 * y + (x + 2) % 5) * W;
                r[l0 +: W] = a[l0 +: W] ^ (~a[l1 +: W] & a[l2 +: W]);
            end
        end
        return r;
    endfunction

    assign chi_next     = chi(state_q);
    assign iter_clamped = (in_iter > MAX_CNT) ? MAX_CNT : in_iter;

    // State register and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            out_q   <= '0;
            cnt     <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            out_q   <= out_d;
            cnt     <= cnt_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = cnt;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = in_data;
                    cnt_d   = iter_clamped;
                    if (iter_clamped == '0) begin
                        out_d = in_data;
                        fsm_d = DONE;
                    end else begin
                        fsm_d = RUN;
                    end
                end
            end
            RUN: begin
                state_d = chi_next;
                cnt_d   = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    out_d = chi_next;
                    fsm_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Handshake flags decode only the registered FSM state.
    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q != IDLE);
    assign out_data  = out_q;

endmodule

// File: doc/chi_iter_engine.md
# chi_iter_engine

Parametrised successor to the single-pass 25-bit revaluate datapath in the encoder. It holds a 5×5×W state and applies the chi (revaluate) step a per-transaction number of times, 0 to MAX_ITER. Registered input and output stages use valid/ready handshakes. It sits between the permutation stage and the round-constant stage of the encoder pipeline.

## Interface
- W, default 1: lane width in bits. State width is 25*W.
- MAX_ITER, default 24: maximum iteration count accepted.
- CW, default 5: width of the iteration-count port; must satisfy 2^CW > MAX_ITER.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input transaction present.
- in_ready  out  1  engine can accept a transaction.
- in_data  in  25*W  input state; lane i = 5*y + x occupies bits [i*W +: W].
- in_iter  in  CW  number of chi applications; values above MAX_ITER are clamped to MAX_ITER.
- out_valid  out  1  result held in the output register.
- out_ready  in  1  downstream accepts the result.
- out_data  out  25*W  result state, same lane layout as in_data.
- busy  out  1  high in RUN or DONE.

## Operation
- chi, per bit z, with x and y in 0..4: out[x][y][z] = a[x][y][z] ^ (~a[(x+1)%5][y][z] & a[(x+2)%5][y][z]).
- FSM states: IDLE, RUN, DONE. Encoding is free; reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: state_q<=in_data and cnt<=min(in_iter,MAX_ITER).
  - If that count is 0: out_q<=in_data and go to DONE.
  - Otherwise go to RUN.
- RUN, once per cycle:
  - state_q<=chi(state_q) and cnt<=cnt-1.
  - When cnt==1: out_q<=chi(state_q) and go to DONE.
- DONE:
  - out_valid=1; out_q is stable.
  - On out_ready go to IDLE.
- in_ready=0 in RUN and DONE. in_valid there is ignored, and the driver must hold it.
- The out_ready handshake completes only in DONE. Input is not accepted in the same cycle that DONE is left; the next acceptance is at earliest the following cycle.
- out_ready while not in DONE has no effect.
- Output only changes on an accepted input:
  - out_data updates only on entry to DONE.
  - After leaving DONE it holds the last result until overwritten.
- Reset values: state IDLE, state_q=0, out_q=0, cnt=0, out_valid=0, busy=0, in_ready=1 (combinational from the IDLE state).
- Reset mid-RUN or mid-DONE aborts the transaction immediately (asynchronous). The result is discarded and out_data reads 0.

## Timing
- Acceptance edge E0 is the edge where IDLE and in_valid are both high.
- Iteration count n=0: out_valid high after E0, so latency is 1 cycle.
- Iteration count n≥1: RUN edges E1..En, with out_valid high after En. Latency is n+1 cycles from E0.
- Throughput: at most one transaction per n+2 cycles, plus any out_ready stall.
- Outputs are registered or decoded from the FSM state. There is no combinational path from in_* or out_ready to any output except:
  - in_ready, which depends only on state.
  - out_valid, which depends only on state.
- One chi evaluation per cycle. The chi logic is purely combinational, 25*W instances of a 3-input function.

## Test plan
- Reset while idle, W=1: rst high asynchronously -> out_valid=0, busy=0, in_ready=1, out_data=0x0000000 before any clock edge.
- Single iteration, W=1: in_data=0x0000002, in_iter=1, out_ready=1 -> out_valid rises 2 cycles after acceptance, out_data=0x0000012, back to IDLE next cycle.
- Two iterations, W=1: in_data=0x0000002, in_iter=2 -> out_data=0x0000006, out_valid rises 3 cycles after acceptance.
- Fixed points and pass-through:
  - in_data=0x1FFFFFF with in_iter=5 -> 0x1FFFFFF.
  - in_data=0x0000000 -> 0x0000000.
  - in_iter=0 with in_data=0x0ABCDEF -> 0x0ABCDEF after 1 cycle.
- Backpressure and clamp, MAX_ITER=24:
  - in_iter=31 -> 24 RUN cycles counted via busy.
  - out_ready low for 10 cycles -> out_valid and out_data stable, in_ready=0 throughout.
  - Accept on out_ready -> in_ready=1 in the following cycle.
- Reset mid-RUN, W=4: start in_iter=10, assert rst at RUN cycle 4 -> immediate IDLE, out_data=0. A fresh transaction afterwards with in_data all-ones and in_iter=3 -> all-ones.
